// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: gates pixels into frames, generates coordinates, frame mode, border mask and frame-done for the Sobel datapath.
// Defining SEQ_ABORT_EN adds the iAbort input, which cancels a frame in progress.
module conv_frame_sequencer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CW       = 11,
  parameter int DW       = 12,
  parameter int PIPE_LAT = 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iStart,
  input  logic [1:0]    iMode,
  input  logic          iMode_WE,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
`ifdef SEQ_ABORT_EN
  input  logic          iAbort,
`endif
  output logic [DW-1:0] oDATA,
  output logic          oDVAL,
  output logic [CW-1:0] oX_Cont,
  output logic [CW-1:0] oY_Cont,
  output logic [1:0]    oMode,
  output logic          oOut_DVAL,
  output logic          oOut_Border,
  output logic          oBusy,
  output logic          oFrame_Done,
  output logic          oOverrun
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, ox_q, ox_d, oy_q, oy_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0] shadow_q, shadow_d, mode_q, mode_d;
  logic dval_q, dval_d, ovr_q, ovr_d;
  logic [PIPE_LAT-1:0] dv_pipe_q, dv_pipe_d, bd_pipe_q, bd_pipe_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic last_col, last_row, abort;
  assign last_col = x_q == CW'(IMG_W - 1);
  assign last_row = y_q == CW'(IMG_H - 1);
`ifdef SEQ_ABORT_EN
  assign abort = iAbort && (state_q == RUN || state_q == DRAIN);
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    data_d    = data_q;
    dval_d    = 1'b0;
    shadow_d  = iMode_WE ? iMode : shadow_q;
    mode_d    = mode_q;
    ovr_d     = ovr_q;
    drain_d   = drain_q;
    // Border flag is computed on the registered coordinate so it stays aligned with oDVAL.
    dv_pipe_d = PIPE_LAT'({dv_pipe_q, dval_q});
    bd_pipe_d = PIPE_LAT'({bd_pipe_q, dval_q && (ox_q < CW'(2) || oy_q < CW'(2))});
    case (state_q)
      IDLE: if (iStart) begin
        state_d = RUN;
        mode_d  = shadow_d;
        ovr_d   = 1'b0;
      end
      RUN: if (iDVAL) begin
        data_d = iDATA;
        dval_d = 1'b1;
        ox_d   = x_q;
        oy_d   = y_q;
        x_d    = last_col ? '0 : x_q + 1'b1;
        y_d    = last_col ? (last_row ? '0 : y_q + 1'b1) : y_q;
        if (last_col && last_row) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        ovr_d   = ovr_q | iDVAL;
        state_d = (drain_q == DCW'(PIPE_LAT - 1)) ? DONE : DRAIN;
        drain_d = drain_q + 1'b1;
      end
      DONE: begin
        ovr_d   = ovr_q | iDVAL;
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d   = IDLE;
      x_d       = '0;
      y_d       = '0;
      ox_d      = ox_q;
      oy_d      = oy_q;
      data_d    = data_q;
      dval_d    = 1'b0;
      dv_pipe_d = '0;
      bd_pipe_d = '0;
    end
  end
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      data_q    <= '0;
      dval_q    <= 1'b0;
      shadow_q  <= '0;
      mode_q    <= '0;
      ovr_q     <= 1'b0;
      drain_q   <= '0;
      dv_pipe_q <= '0;
      bd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      data_q    <= data_d;
      dval_q    <= dval_d;
      shadow_q  <= shadow_d;
      mode_q    <= mode_d;
      ovr_q     <= ovr_d;
      drain_q   <= drain_d;
      dv_pipe_q <= dv_pipe_d;
      bd_pipe_q <= bd_pipe_d;
    end
  end
  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = ox_q;
  assign oY_Cont     = oy_q;
  assign oMode       = mode_q;
  assign oOut_DVAL   = dv_pipe_q[PIPE_LAT-1];
  assign oOut_Border = bd_pipe_q[PIPE_LAT-1];
  assign oBusy       = state_q != IDLE;
  assign oFrame_Done = state_q == DONE;
  assign oOverrun    = ovr_q;
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: scoreboard bench for conv_frame_sequencer on a 4x4 frame.
module tb_conv_frame_sequencer;
  localparam int W = 4, H = 4, CW = 11, DW = 12, PL = 1;
  logic iCLK = 0, iRST = 0, iStart = 0, iMode_WE = 0, iDVAL = 0;
  logic [1:0] iMode = 0;
  logic [DW-1:0] iDATA = 0;
`ifdef SEQ_ABORT_EN
  logic iAbort = 0;
`endif
  logic [DW-1:0] oDATA;
  logic [CW-1:0] oX_Cont, oY_Cont;
  logic [1:0] oMode;
  logic oDVAL, oOut_DVAL, oOut_Border, oBusy, oFrame_Done, oOverrun;

  conv_frame_sequencer #(.IMG_W(W), .IMG_H(H), .CW(CW), .DW(DW), .PIPE_LAT(PL)) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iMode(iMode), .iMode_WE(iMode_WE),
    .iDATA(iDATA), .iDVAL(iDVAL),
`ifdef SEQ_ABORT_EN
    .iAbort(iAbort),
`endif
    .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oMode(oMode),
    .oOut_DVAL(oOut_DVAL), .oOut_Border(oOut_Border), .oBusy(oBusy),
    .oFrame_Done(oFrame_Done), .oOverrun(oOverrun));

  always #5 iCLK = ~iCLK;

  int errors = 0, checks = 0;
  logic [DW+2*CW-1:0] exp_q[$];
  logic bq[$];
  logic b;
  int out_idx = 0, fd_cnt = 0, bord_n = 0, int_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge iCLK) begin
    if (!iRST) begin
      exp_q.delete();
      bq.delete();
      out_idx = 0;
    end else begin
      if (oDVAL) begin
        if (exp_q.size() == 0) check("dval_extra", oDVAL, 1'b0);
        else check("pix", {oDATA, oX_Cont, oY_Cont}, exp_q.pop_front());
      end
      if (oOut_DVAL) begin
        if (bq.size() == 0) check("out_dval_extra", oOut_DVAL, 1'b0);
        else begin
          b = bq.pop_front();
          check("border", oOut_Border, b);
        end
        if (oOut_Border) bord_n++;
        else int_n++;
        check("frame_done_align", oFrame_Done, out_idx == W * H - 1);
        out_idx++;
      end else begin
        check("border_idle", oOut_Border, 1'b0);
        check("done_alone", oFrame_Done, 1'b0);
      end
      if (oFrame_Done) fd_cnt++;
      if (!oBusy) out_idx = 0;
    end
  end

  task automatic run_frame(input bit gap, input bit mid, input bit swe, input logic [1:0] smode,
                           input logic [1:0] emode, input bit ovr);
    int fd0, b0, i0;
    fd0 = fd_cnt;
    b0 = bord_n;
    i0 = int_n;
    @(posedge iCLK); #1;
    iStart = 1; iMode_WE = swe; iMode = smode;
    @(posedge iCLK); #1;
    iStart = 0; iMode_WE = 0;
    @(negedge iCLK);
    check("start_busy", oBusy, 1'b1);
    check("start_mode", oMode, emode);
    check("start_ovr", oOverrun, 1'b0);
    for (int i = 0; i < W * H; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      @(posedge iCLK); #1;
      iDVAL = 1;
      iDATA = DW'(i);
      iStart = mid && i == 6;
      iMode_WE = mid && i == 4;
      if (mid && i == 4) iMode = 2'd1;
      exp_q.push_back({DW'(i), CW'(c), CW'(r)});
      bq.push_back(r < 2 || c < 2);
      if (gap) begin
        if (i > 0) begin
          @(negedge iCLK);
          check("gap_dval", oDVAL, 1'b0);
          check("gap_hold", {oDATA, oX_Cont, oY_Cont}, {DW'(i - 1), CW'((i - 1) % W), CW'((i - 1) / W)});
        end
        @(posedge iCLK); #1;
        iDVAL = 0; iStart = 0; iMode_WE = 0;
      end
    end
    if (!gap) begin
      @(posedge iCLK); #1;
      iDVAL = 0; iStart = 0; iMode_WE = 0;
    end
    @(posedge iCLK); #1;
    iDVAL = ovr;
    @(posedge iCLK); #1;
    iDVAL = 0;
    for (int k = 0; k < 20 && fd_cnt == fd0; k++) @(posedge iCLK);
    check("frame_done_cnt", fd_cnt, fd0 + 1);
    @(negedge iCLK);
    check("end_busy", oBusy, 1'b0);
    check("end_mode", oMode, emode);
    check("end_ovr", oOverrun, ovr);
    check("border_n", bord_n - b0, 12);
    check("interior_n", int_n - i0, 4);
    check("queue_empty", exp_q.size(), 0);
    @(posedge iCLK); #1;
    iDVAL = 1;
    @(posedge iCLK); #1;
    iDVAL = 0;
    @(negedge iCLK);
    check("idle_dval", oDVAL, 1'b0);
    check("idle_ovr", oOverrun, ovr);
  endtask

  task automatic partial_frame();
    @(posedge iCLK); #1;
    iStart = 1;
    @(posedge iCLK); #1;
    iStart = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge iCLK); #1;
      iDVAL = 1;
      iDATA = DW'(i);
      exp_q.push_back({DW'(i), CW'(i % W), CW'(i / W)});
      bq.push_back((i / W) < 2 || (i % W) < 2);
    end
  endtask

  initial begin
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_data", oDATA, 0);
    check("rst_dval", oDVAL, 0);
    check("rst_xy", {oX_Cont, oY_Cont}, 0);
    check("rst_mode", oMode, 0);
    check("rst_out", {oOut_DVAL, oOut_Border}, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oFrame_Done, 0);
    check("rst_ovr", oOverrun, 0);
    @(posedge iCLK); #1;
    iRST = 1;
    @(posedge iCLK); #1;
    iMode_WE = 1; iMode = 2'd2;
    @(posedge iCLK); #1;
    iMode_WE = 0;
    run_frame(0, 0, 0, 2'd0, 2'd2, 0);
    run_frame(1, 1, 0, 2'd0, 2'd2, 1);
    run_frame(0, 0, 0, 2'd0, 2'd1, 0);
    run_frame(0, 0, 1, 2'd3, 2'd3, 0);
    partial_frame();
    @(posedge iCLK); #1;
    iDVAL = 0;
    iRST = 0;
    @(negedge iCLK);
    check("mid_rst_dval", oDVAL, 0);
    check("mid_rst_busy", oBusy, 0);
    check("mid_rst_xy", {oX_Cont, oY_Cont}, 0);
    check("mid_rst_data", oDATA, 0);
    check("mid_rst_mode", oMode, 0);
    check("mid_rst_out", oOut_DVAL, 0);
    @(posedge iCLK); #1;
    iRST = 1;
    run_frame(0, 0, 0, 2'd0, 2'd0, 0);
`ifdef SEQ_ABORT_EN
    begin
      int fd0;
      fd0 = fd_cnt;
      partial_frame();
      @(posedge iCLK); #1;
      iDATA = 12'h63;
      iAbort = 1;
      @(posedge iCLK); #1;
      iDVAL = 0;
      iAbort = 0;
      @(negedge iCLK);
      check("abort_busy", oBusy, 0);
      check("abort_dval", oDVAL, 0);
      check("abort_out", oOut_DVAL, 0);
      check("abort_flush", bq.size(), 1);
      bq.delete();
      repeat (4) @(posedge iCLK);
      check("abort_no_done", fd_cnt, fd0);
      run_frame(0, 0, 0, 2'd0, 2'd0, 0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
